// File: rtl/lut_table_pkg.sv
// lut_table_pkg: shared types and helpers for the programmable key/data table.
// Holds the FSM state enum, pair-slicing offsets for the packed lut bus and a
// constant-evaluable clog2 used to size index and count fields.
package lut_table_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Ceiling log2 with a floor of 1 so that index fields never collapse to zero width
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Lowest bit of pair n on the packed lut bus
   function automatic int pair_lo(input int n, input int pair_len);
      return n * pair_len;
   endfunction

   // Highest bit of pair n on the packed lut bus
   function automatic int pair_hi(input int n, input int pair_len);
      return (n + 1) * pair_len - 1;
   endfunction

endpackage

// File: rtl/lut_table_match.sv
// lut_table_match: combinational priority matcher. Compares a needle against
// NR enabled entries and reports a hit plus the lowest matching index
// (index is 0 on a miss).
module lut_table_match
   import lut_table_pkg::*;
#(
   parameter int NR    = 4,
   parameter int W     = 8,
   parameter int IDX_W = clog2(NR)
) (
   input  logic [NR*W-1:0]  i_entries,
   input  logic [NR-1:0]    i_en,
   input  logic [W-1:0]     i_needle,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_idx
);

   // Scan from the top down so the last assignment is the lowest matching index
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int n = NR - 1; n >= 0; n--) begin
         if (i_en[n] && (i_entries[n*W +: W] == i_needle)) begin
            o_hit = 1'b1;
            o_idx = IDX_W'(n);
         end
      end
   end

endmodule

// File: rtl/lut_table.sv
// lut_table: programmable key/data table that builds the packed lut bus for the
// key-select mux, with a clear sweep FSM and a registered reverse (data -> key)
// search. Optional build macro LUT_TABLE_DEDUP_EN makes a write to an already
// present key overwrite that entry's data in place instead of appending.
module lut_table
   import lut_table_pkg::*;
#(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 3,
   parameter int DATA_LEN = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr_req,
   input  logic                                 wr_valid,
   output logic                                 wr_ready,
   input  logic [KEY_LEN-1:0]                   wr_key,
   input  logic [DATA_LEN-1:0]                  wr_data,
   input  logic                                 srch_valid,
   input  logic [DATA_LEN-1:0]                  srch_data,
   output logic                                 srch_rsp_valid,
   output logic                                 srch_hit,
   output logic [KEY_LEN-1:0]                   srch_key,
   output logic [clog2(NR_KEY)-1:0]             srch_idx,
   output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
   output logic [NR_KEY-1:0]                    valid_mask,
   output logic [clog2(NR_KEY+1)-1:0]           count,
   output logic                                 busy
);

   localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
   localparam int IDX_W    = clog2(NR_KEY);
   localparam int CNT_W    = clog2(NR_KEY + 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [KEY_LEN-1:0]    r_key  [NR_KEY];
   logic [DATA_LEN-1:0]   r_data [NR_KEY];
   logic [NR_KEY-1:0]     r_valid;
   logic [CNT_W-1:0]      r_count;
   logic [IDX_W-1:0]      r_ptr;
   logic [IDX_W-1:0]      r_clr_idx;

   logic                  r_rsp_valid;
   logic                  r_hit;
   logic [KEY_LEN-1:0]    r_srch_key;
   logic [IDX_W-1:0]      r_srch_idx;

   logic [NR_KEY*DATA_LEN-1:0] w_data_flat;
   logic                  w_srch_hit;
   logic [IDX_W-1:0]      w_srch_idx;
   logic                  w_room;
   logic                  w_wr_fire;
   logic                  w_clr_last;

   // Flatten stored data for the search matcher
   always_comb begin
      w_data_flat = '0;
      for (int n = 0; n < NR_KEY; n++) begin
         w_data_flat[n*DATA_LEN +: DATA_LEN] = r_data[n];
      end
   end

   lut_table_match #(
      .NR    (NR_KEY),
      .W     (DATA_LEN),
      .IDX_W (IDX_W)
   ) u_srch_match (
      .i_entries (w_data_flat),
      .i_en      (r_valid),
      .i_needle  (srch_data),
      .o_hit     (w_srch_hit),
      .o_idx     (w_srch_idx)
   );

`ifdef LUT_TABLE_DEDUP_EN
   logic [NR_KEY*KEY_LEN-1:0] w_key_flat;
   logic                      w_key_match;
   logic [IDX_W-1:0]          w_key_idx;

   // Flatten stored keys for the duplicate-key matcher
   always_comb begin
      w_key_flat = '0;
      for (int n = 0; n < NR_KEY; n++) begin
         w_key_flat[n*KEY_LEN +: KEY_LEN] = r_key[n];
      end
   end

   lut_table_match #(
      .NR    (NR_KEY),
      .W     (KEY_LEN),
      .IDX_W (IDX_W)
   ) u_key_match (
      .i_entries (w_key_flat),
      .i_en      (r_valid),
      .i_needle  (wr_key),
      .o_hit     (w_key_match),
      .o_idx     (w_key_idx)
   );

   assign w_room = (r_count < CNT_W'(NR_KEY)) | w_key_match;
`else
   assign w_room = (r_count < CNT_W'(NR_KEY));
`endif

   // A clear request in the same cycle as a write takes priority over the write
   assign wr_ready   = (r_state == ST_IDLE) & ~clr_req & w_room;
   assign w_wr_fire  = wr_valid & wr_ready;
   assign w_clr_last = (r_clr_idx == IDX_W'(NR_KEY - 1));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state: a clear sweep visits every entry once, then returns to idle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (clr_req)    w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   // Table storage, write pointer, count and clear sweep index
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NR_KEY; n++) begin
            r_key[n]  <= '0;
            r_data[n] <= '0;
         end
         r_valid   <= '0;
         r_count   <= '0;
         r_ptr     <= '0;
         r_clr_idx <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_key[r_clr_idx]   <= '0;
         r_data[r_clr_idx]  <= '0;
         r_valid[r_clr_idx] <= 1'b0;
         if (w_clr_last) begin
            r_count   <= '0;
            r_ptr     <= '0;
            r_clr_idx <= '0;
         end else begin
            r_clr_idx <= r_clr_idx + IDX_W'(1);
         end
      end else if (w_wr_fire) begin
`ifdef LUT_TABLE_DEDUP_EN
         if (w_key_match) begin
            r_data[w_key_idx] <= wr_data;
         end else begin
            r_key[r_ptr]   <= wr_key;
            r_data[r_ptr]  <= wr_data;
            r_valid[r_ptr] <= 1'b1;
            r_ptr          <= r_ptr + IDX_W'(1);
            r_count        <= r_count + CNT_W'(1);
         end
`else
         r_key[r_ptr]   <= wr_key;
         r_data[r_ptr]  <= wr_data;
         r_valid[r_ptr] <= 1'b1;
         r_ptr          <= r_ptr + IDX_W'(1);
         r_count        <= r_count + CNT_W'(1);
`endif
      end
   end

   // Search response register; compares against pre-update table contents
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_hit       <= 1'b0;
         r_srch_key  <= '0;
         r_srch_idx  <= '0;
      end else begin
         r_rsp_valid <= srch_valid;
         r_hit       <= w_srch_hit;
         r_srch_key  <= w_srch_hit ? r_key[w_srch_idx] : '0;
         r_srch_idx  <= w_srch_hit ? w_srch_idx : '0;
      end
   end

   // Pack the table onto the lut bus; invalid entries drive zero pairs
   always_comb begin
      lut = '0;
      for (int n = 0; n < NR_KEY; n++) begin
         lut[pair_lo(n, PAIR_LEN) +: PAIR_LEN] = r_valid[n] ? {r_key[n], r_data[n]} : '0;
      end
   end

   assign valid_mask     = r_valid;
   assign count          = r_count;
   assign busy           = (r_state == ST_CLEAR);
   assign srch_rsp_valid = r_rsp_valid;
   assign srch_hit       = r_hit;
   assign srch_key       = r_srch_key;
   assign srch_idx       = r_srch_idx;

endmodule
